// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detection_unit
//  Purpose  : Load-use hazard detector for the five-stage RISC-V pipeline.
//             Sits between IF/ID and ID/EX. When the instruction in EX is a
//             load whose rd is a source of the instruction in ID, the front
//             end is frozen for one cycle (PC and IF/ID hold) and a bubble is
//             steered into ID/EX. A saturating counter records stall cycles.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    COUNT_WIDTH          width of the stall-cycle counter
//  Ports
//    clk                  pipeline clock (counter updates on rising edge)
//    rst_n                asynchronous active-low reset
//    ID_EX_Memread        MemRead of the instruction in EX (1 = load)
//    IF_ID_Rs1            rs1 field of the instruction in ID
//    IF_ID_Rs2            rs2 field of the instruction in ID
//    ID_EX_Rd             rd field of the instruction in EX
//    control_unit_select  1 = drive zeroed (bubble) controls into ID/EX
//    PC_Write             1 = PC may update, 0 = hold PC
//    IF_ID_Write          1 = IF/ID may load, 0 = hold IF/ID
//    stall_count          stall cycles seen since reset (saturating)
// ============================================================================
module hazard_detection_unit #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ID_EX_Memread,
  input  logic [4:0]             IF_ID_Rs1,
  input  logic [4:0]             IF_ID_Rs2,
  input  logic [4:0]             ID_EX_Rd,
  output logic                   control_unit_select,
  output logic                   PC_Write,
  output logic                   IF_ID_Write,
  output logic [COUNT_WIDTH-1:0] stall_count
);

  localparam logic [COUNT_WIDTH-1:0] c_count_one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic                   w_rd_nonzero;
  logic                   w_rs1_match;
  logic                   w_rs2_match;
  logic                   w_hazard;
  logic                   w_stall;
  logic                   w_count_full;
  logic [COUNT_WIDTH-1:0] stall_count_d;
  logic [COUNT_WIDTH-1:0] stall_count_q;

  // Source fields are compared regardless of instruction format; a false
  // stall on an unused field only costs a cycle and is never incorrect.
  // x0 can never carry a load result, so rd = 0 is excluded outright.
  always_comb begin
    w_rd_nonzero = (ID_EX_Rd != 5'd0);
    w_rs1_match  = (ID_EX_Rd == IF_ID_Rs1);
    w_rs2_match  = (ID_EX_Rd == IF_ID_Rs2);
    w_hazard     = ID_EX_Memread & w_rd_nonzero & (w_rs1_match | w_rs2_match);
  end

  // Stall outputs are purely combinational; reset forces the no-stall values
  // so a held pipeline cannot be wedged while the core is in reset.
  always_comb begin
    w_stall             = w_hazard & rst_n;
    control_unit_select = w_stall;
    PC_Write            = ~w_stall;
    IF_ID_Write         = ~w_stall;
  end

  // Saturating stall-cycle counter: sticks at all-ones instead of wrapping.
  always_comb begin
    w_count_full  = &stall_count_q;
    stall_count_d = stall_count_q;
    if (w_hazard && !w_count_full) begin
      stall_count_d = stall_count_q + c_count_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_detection_unit
//  Purpose  : Scoreboard bench for hazard_detection_unit. Two instances share
//             the same stimulus: a 32-bit counter and a 2-bit counter whose
//             saturation can be observed quickly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mr;
  logic [4:0] rs1, rs2, rd;

  logic        sel_a, pcw_a, ifw_a;
  logic [31:0] cnt_a;
  logic        sel_b, pcw_b, ifw_b;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  hazard_detection_unit #(.COUNT_WIDTH(32)) u_dut32 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ID_EX_Memread       (mr),
    .IF_ID_Rs1           (rs1),
    .IF_ID_Rs2           (rs2),
    .ID_EX_Rd            (rd),
    .control_unit_select (sel_a),
    .PC_Write            (pcw_a),
    .IF_ID_Write         (ifw_a),
    .stall_count         (cnt_a)
  );

  hazard_detection_unit #(.COUNT_WIDTH(2)) u_dut2 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ID_EX_Memread       (mr),
    .IF_ID_Rs1           (rs1),
    .IF_ID_Rs2           (rs2),
    .ID_EX_Rd            (rd),
    .control_unit_select (sel_b),
    .PC_Write            (pcw_b),
    .IF_ID_Write         (ifw_b),
    .stall_count         (cnt_b)
  );

  typedef struct {
    logic        stall;
    logic [31:0] total;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;
  int   total  = 0;   // stall cycles counted by the reference since reset

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive between edges, predict the response, and
  // advance the reference count for the coming rising edge.
  task automatic apply(input logic m, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input bit rst_pulse);
    bit   hz;
    exp_t e;
    @(negedge clk);
    mr  = m;
    rs1 = a;
    rs2 = b;
    rd  = d;
    if (rst_pulse) begin
      rst_n = 1'b0;
      total = 0;
    end
    hz      = m && (d != 0) && (d == a || d == b);
    e.stall = hz && !rst_pulse;
    e.total = total;
    q.push_back(e);
    -> sample_ev;
    if (rst_pulse) begin
      #4;
      rst_n = 1'b1;
    end
    if (hz) total++;
  endtask

  // Monitor: samples the DUT outputs shortly after each stimulus update.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #2;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
        e = q.pop_front();
        chk("select32",  64'(sel_a), 64'(e.stall));
        chk("pc_write32", 64'(pcw_a), 64'(!e.stall));
        chk("ifid_write32", 64'(ifw_a), 64'(!e.stall));
        chk("count32", 64'(cnt_a), 64'(e.total));
        chk("select2",  64'(sel_b), 64'(e.stall));
        chk("pc_write2", 64'(pcw_b), 64'(!e.stall));
        chk("ifid_write2", 64'(ifw_b), 64'(!e.stall));
        chk("count2", 64'(cnt_b), 64'((e.total > 3) ? 3 : e.total));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    mr    = 1'b0;
    rs1   = '0;
    rs2   = '0;
    rd    = '0;

    // Reset state, with a would-be hazard present while in reset.
    apply(1'b1, 5'd5, 5'd6, 5'd5, 1'b1);

    // Directed cases.
    apply(1'b0, 5'd1,  5'd2,  5'd3,  1'b0);
    apply(1'b1, 5'd5,  5'd6,  5'd5,  1'b0);
    apply(1'b1, 5'd4,  5'd7,  5'd7,  1'b0);
    apply(1'b1, 5'd10, 5'd10, 5'd10, 1'b0);
    apply(1'b1, 5'd1,  5'd2,  5'd3,  1'b0);
    apply(1'b1, 5'd0,  5'd0,  5'd0,  1'b0);
    apply(1'b1, 5'd4,  5'd4,  5'd3,  1'b0);
    apply(1'b0, 5'd9,  5'd9,  5'd9,  1'b0);

    // Hold a hazard three edges, clear it, then reset mid-stall.
    apply(1'b1, 5'd0,  5'd0,  5'd0,  1'b1);
    apply(1'b1, 5'd5,  5'd6,  5'd5,  1'b0);
    apply(1'b1, 5'd5,  5'd6,  5'd5,  1'b0);
    apply(1'b1, 5'd5,  5'd6,  5'd5,  1'b0);
    apply(1'b0, 5'd1,  5'd2,  5'd3,  1'b0);
    apply(1'b1, 5'd5,  5'd6,  5'd5,  1'b1);

    // Five further hazard edges: 2-bit counter must stick at 3.
    for (int i = 0; i < 5; i++) apply(1'b1, 5'd8, 5'd31, 5'd31, 1'b0);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Randomized traffic with small register ranges so matches are common.
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            $urandom_range(0, 49) == 0);
    end
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Load-use hazard detector for the five-stage RISC-V pipeline, sitting between the IF/ID and ID/EX pipeline registers. When the instruction in EX is a load whose destination register is a source of the instruction in ID, it stalls the front end for one cycle by freezing the PC and IF/ID and selecting the NOP control path into ID/EX. It also keeps a saturating count of stall cycles for performance monitoring.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock; counter updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- ID_EX_Memread  input  1  MemRead control bit of the instruction in EX (1 = load).
- IF_ID_Rs1  input  5  rs1 field of the instruction in ID.
- IF_ID_Rs2  input  5  rs2 field of the instruction in ID.
- ID_EX_Rd  input  5  rd field of the instruction in EX.
- control_unit_select  output  1  1 = drive zeroed (bubble) control signals into ID/EX.
- PC_Write  output  1  1 = PC may update; 0 = hold PC.
- IF_ID_Write  output  1  1 = IF/ID may load; 0 = hold IF/ID.
- stall_count  output  COUNT_WIDTH  number of cycles in which a stall was asserted since reset.

## Operation
- hazard = ID_EX_Memread AND (ID_EX_Rd != 0) AND ((ID_EX_Rd == IF_ID_Rs1) OR (ID_EX_Rd == IF_ID_Rs2)).
- x0 is never a hazard source: ID_EX_Rd = 0 gives no hazard even when Rs1/Rs2 = 0.
- Rs1 == Rs2 does not by itself create a hazard; a match against ID_EX_Rd is always required.
- A hazard on Rs1, on Rs2, or on both produces the same response.
- When hazard = 1: control_unit_select = 1, PC_Write = 0, IF_ID_Write = 0.
- When hazard = 0: control_unit_select = 0, PC_Write = 1, IF_ID_Write = 1.
- Source-field matching is unconditional. Rs fields are compared even for instruction formats that do not use them. Such false stalls are conservative and permitted.
- While rst_n = 0, outputs take the no-stall values: control_unit_select = 0, PC_Write = 1, IF_ID_Write = 1.
- stall_count increments by 1 on each rising clk edge where hazard = 1 and rst_n = 1.
- stall_count saturates at all-ones and does not wrap.

## Timing
- control_unit_select, PC_Write and IF_ID_Write are purely combinational from the inputs and rst_n, with zero-cycle latency. They must settle within the same cycle so the pipeline registers see them at the next edge.
- No internal state influences the stall outputs. The one-cycle stall length comes from the pipeline: after the bubble enters ID/EX, ID_EX_Memread drops and the hazard clears.
- stall_count reset value is 0. Reset is applied asynchronously on the falling edge of rst_n. Release is synchronous in effect: the first increment can occur on the first rising edge after rst_n = 1.
- Asserting reset mid-stall clears stall_count immediately and forces the no-stall output values.
- Back-to-back hazard cycles are each counted. Input changes between edges do not affect the count; it is sampled at the edge only.

## Test plan
- MemRead=0, Rs1=1, Rs2=2, Rd=3 -> select=0, PC_Write=1, IF_ID_Write=1; count unchanged.
- MemRead=1, Rs1=5, Rs2=6, Rd=5 -> select=1, PC_Write=0, IF_ID_Write=0. Repeat with Rs1=4, Rs2=7, Rd=7, and with Rs1=Rs2=Rd=10 -> same stall response each time.
- MemRead=1, Rs1=1, Rs2=2, Rd=3 -> no stall. MemRead=1, Rs1=Rs2=Rd=0 -> no stall. MemRead=1, Rs1=Rs2=4, Rd=3 -> no stall.
- Hold a hazard for 3 clock edges, then clear it -> stall_count = 3. Then pulse rst_n low between edges -> stall_count = 0 immediately and outputs at no-stall values while rst_n = 0.
- With COUNT_WIDTH=2, hold a hazard for 5 edges -> stall_count reads 1, 2, 3, 3, 3 (saturates, no wrap).
